// File: rtl/core_msg_receiver_pkg.sv
// rtl/core_msg_receiver_pkg.sv - shared encodings for the scheduler->core message receiver
package core_msg_receiver_pkg;

    localparam int          SCHED_MSG_BUS_WIDTH = 16;
    localparam logic [15:0] SCHED_IFNUM_MASK    = 16'h003F;
    localparam logic [15:0] SCHED_FENCE_MASK    = 16'h00C0;

    typedef enum logic [1:0] {
        RX_ST_IDLE = 2'd0,
        RX_ST_HDR  = 2'd1,
        RX_ST_LOAD = 2'd2,
        RX_ST_SKIP = 2'd3
    } rx_state_t;

    // Word offsets inside the header frame
    localparam logic [3:0] HDR_W_HDR    = 4'd0;
    localparam logic [3:0] HDR_W_MASK   = 4'd1;
    localparam logic [3:0] HDR_W_R0SEL  = 4'd2;
    localparam logic [3:0] HDR_W_R0BASE = 4'd3;

endpackage

// File: rtl/core_msg_receiver_rx_instr_buf.sv
// rtl/core_msg_receiver_rx_instr_buf.sv - local instruction buffer, 1 write port, 1 registered read port
module core_msg_receiver_rx_instr_buf #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/core_msg_receiver.sv
// rtl/core_msg_receiver.sv - core-side receiver: frame alignment, header decode, instruction load/skip
module core_msg_receiver
    import core_msg_receiver_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int INSTR_SIZE = SCHED_MSG_BUS_WIDTH,
    parameter int FRAME_SIZE = 16,
    parameter int IMEM_DEPTH = 256,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_loading,
    input  logic [INSTR_SIZE-1:0] mess_to_core,
    output logic                  core_reading,
    output logic                  core_ready,
    output logic                  task_valid,
    output logic [INSTR_SIZE-1:0] r0_value,
    output logic [9:0]            instr_len,
    input  logic [AW-1:0]         instr_rd_addr,
    output logic [INSTR_SIZE-1:0] instr_rd_data,
    input  logic                  task_done,
    output logic                  err_overflow,
    output logic                  err_busy_hit
);

    localparam logic [AW:0] WPTR_ONE = (AW + 1)'(1);

    rx_state_t   state, state_next;
    logic        rd_d1;
    logic [3:0]  wcnt;
    logic [5:0]  fcnt;
    logic        sel;
    logic [AW:0] wptr;
    logic        last_word;
    logic        core_hit;
    logic        is_hdr;
    logic        buf_we;

    assign last_word = (wcnt == 4'(FRAME_SIZE - 1));
    assign core_hit  = |(mess_to_core[CORE_NUM-1:0] & (CORE_NUM'(1) << CORE_ID));
    assign is_hdr    = (state == RX_ST_IDLE) || (state == RX_ST_HDR);
    // wptr MSB set means the buffer is full; later words are dropped
    assign buf_we    = rd_d1 && (state == RX_ST_LOAD) && !wptr[AW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_reading <= 1'b0;
            rd_d1        <= 1'b0;
        end else begin
            core_reading <= !prog_loading;
            rd_d1        <= core_reading;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RX_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (rd_d1) begin
            case (state)
                RX_ST_IDLE: state_next = RX_ST_HDR;
                RX_ST_HDR: begin
                    if (last_word && fcnt != 6'd0) begin
                        state_next = sel ? RX_ST_LOAD : RX_ST_SKIP;
                    end
                end
                default: begin
                    if (last_word && fcnt == 6'd1) begin
                        state_next = RX_ST_HDR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt         <= 4'd0;
            fcnt         <= 6'd0;
            sel          <= 1'b0;
            wptr         <= '0;
            r0_value     <= '0;
            instr_len    <= 10'd0;
            task_valid   <= 1'b0;
            core_ready   <= 1'b1;
            err_overflow <= 1'b0;
            err_busy_hit <= 1'b0;
        end else begin
            if (rd_d1) begin
                wcnt <= wcnt + 4'd1;
                if (is_hdr) begin
                    case (wcnt)
                        HDR_W_HDR:    fcnt <= 6'(mess_to_core[15:0] & SCHED_IFNUM_MASK);
                        HDR_W_R0SEL: begin
                            // A busy core still receives the stream but treats it as someone else's
                            sel <= core_hit && core_ready;
                            if (core_hit && !core_ready) begin
                                err_busy_hit <= 1'b1;
                            end
                        end
                        HDR_W_R0BASE: begin
                            if (sel) begin
                                r0_value <= mess_to_core + INSTR_SIZE'(CORE_ID);
                            end
                        end
                        default: ;
                    endcase
                    if (last_word && fcnt != 6'd0 && sel) begin
                        wptr      <= '0;
                        instr_len <= 10'd0;
                    end
                end else begin
                    if (state == RX_ST_LOAD) begin
                        if (wptr[AW]) begin
                            err_overflow <= 1'b1;
                        end else begin
                            wptr      <= wptr + WPTR_ONE;
                            instr_len <= instr_len + 10'd1;
                        end
                    end
                    if (last_word) begin
                        fcnt <= fcnt - 6'd1;
                        if (state == RX_ST_LOAD && fcnt == 6'd1) begin
                            task_valid <= 1'b1;
                            core_ready <= 1'b0;
                        end
                    end
                end
            end
            if (task_done && task_valid) begin
                task_valid <= 1'b0;
                core_ready <= 1'b1;
                wptr       <= '0;
            end
        end
    end

    core_msg_receiver_rx_instr_buf #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (INSTR_SIZE)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (mess_to_core),
        .rd_addr (instr_rd_addr),
        .rd_data (instr_rd_data)
    );

endmodule

// File: tb/tb_core_msg_receiver.sv
// tb/tb_core_msg_receiver.sv - self-checking bench for core_msg_receiver (CORE_ID=3, depths 256 and 16)
module tb_core_msg_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prog_loading = 1'b0;
    logic        task_done = 1'b0;
    logic [15:0] mess_to_core = 16'h0;
    logic [7:0]  rd_addr0 = 8'h0;
    logic [3:0]  rd_addr1;

    logic        core_reading0, core_ready0, task_valid0, err_ovf0, err_busy0;
    logic        core_reading1, core_ready1, task_valid1, err_ovf1, err_busy1;
    logic [15:0] r0_value0, r0_value1, rd_data0, rd_data1;
    logic [9:0]  instr_len0, instr_len1;

    assign rd_addr1 = rd_addr0[3:0];

    always #5 clk = ~clk;

    core_msg_receiver #(.CORE_ID(3), .IMEM_DEPTH(256)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .prog_loading  (prog_loading),
        .mess_to_core  (mess_to_core),
        .core_reading  (core_reading0),
        .core_ready    (core_ready0),
        .task_valid    (task_valid0),
        .r0_value      (r0_value0),
        .instr_len     (instr_len0),
        .instr_rd_addr (rd_addr0),
        .instr_rd_data (rd_data0),
        .task_done     (task_done),
        .err_overflow  (err_ovf0),
        .err_busy_hit  (err_busy0)
    );

    core_msg_receiver #(.CORE_ID(3), .IMEM_DEPTH(16)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .prog_loading  (prog_loading),
        .mess_to_core  (mess_to_core),
        .core_reading  (core_reading1),
        .core_ready    (core_ready1),
        .task_valid    (task_valid1),
        .r0_value      (r0_value1),
        .instr_len     (instr_len1),
        .instr_rd_addr (rd_addr1),
        .instr_rd_data (rd_data1),
        .task_done     (task_done),
        .err_overflow  (err_ovf1),
        .err_busy_hit  (err_busy1)
    );

    int errors = 0;
    int checks = 0;

    // Scheduler side: bit 16 marks a real message word, zero fill frames are unmarked
    logic [16:0] q[$];
    int          pending = 0;
    logic        rd_seen = 1'b0;
    logic [15:0] pl[$];

    // Reference: outcome of each whole message, independent of word timing
    logic        m_ready, m_valid, m_busy, m_ovf0, m_ovf1;
    logic [15:0] m_r0;
    int          m_len0, m_len1;
    logic [15:0] m_buf[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
        m_r0 = 16'h0; m_len0 = 0; m_len1 = 0;
        m_buf.delete();
    endtask

    task automatic gen_pl(input int n, input logic directed);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(directed ? 16'(16'hA000 + i) : 16'($urandom));
    endtask

    task automatic push_msg(input int if_num, input logic [15:0] mask, input logic [15:0] base);
        q.push_back({1'b1, 8'h00, 2'($urandom), 6'(if_num)});
        q.push_back({1'b1, 16'($urandom)});
        q.push_back({1'b1, mask});
        q.push_back({1'b1, base});
        for (int i = 0; i < 12; i++) q.push_back({1'b1, 16'($urandom)});
        for (int i = 0; i < if_num * 16; i++) q.push_back({1'b1, pl[i]});
        pending += 16 + if_num * 16;
    endtask

    task automatic model_msg(input int if_num, input logic [15:0] mask, input logic [15:0] base);
        int n;
        if (mask[3]) begin
            if (!m_ready) begin
                m_busy = 1'b1;
            end else begin
                m_r0 = base + 16'd3;
                if (if_num > 0) begin
                    n = if_num * 16;
                    m_buf = pl;
                    m_len0 = (n > 256) ? 256 : n;
                    m_len1 = (n > 16) ? 16 : n;
                    if (n > 256) m_ovf0 = 1'b1;
                    if (n > 16) m_ovf1 = 1'b1;
                    m_valid = 1'b1;
                    m_ready = 1'b0;
                end
            end
        end
    endtask

    task automatic send_msg(input int if_num, input logic [15:0] mask, input logic [15:0] base);
        push_msg(if_num, mask, base);
        model_msg(if_num, mask, base);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (pending > 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", pending, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        task_done = 1'b1;
        @(negedge clk);
        task_done = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string s);
        check($sformatf("%s.reading", s), core_reading0, 1);
        check($sformatf("%s.ready0", s), core_ready0, m_ready);
        check($sformatf("%s.ready1", s), core_ready1, m_ready);
        check($sformatf("%s.valid0", s), task_valid0, m_valid);
        check($sformatf("%s.valid1", s), task_valid1, m_valid);
        check($sformatf("%s.r0_0", s), r0_value0, m_r0);
        check($sformatf("%s.r0_1", s), r0_value1, m_r0);
        check($sformatf("%s.len0", s), instr_len0, m_len0);
        check($sformatf("%s.len1", s), instr_len1, m_len1);
        check($sformatf("%s.busy0", s), err_busy0, m_busy);
        check($sformatf("%s.busy1", s), err_busy1, m_busy);
        check($sformatf("%s.ovf0", s), err_ovf0, m_ovf0);
        check($sformatf("%s.ovf1", s), err_ovf1, m_ovf1);
        if (m_valid) begin
            for (int i = 0; i < m_len0; i++) begin
                rd_addr0 = 8'(i);
                @(negedge clk);
                check($sformatf("%s.buf0[%0d]", s, i), rd_data0, m_buf[i]);
                if (i < m_len1) check($sformatf("%s.buf1[%0d]", s, i), rd_data1, m_buf[i]);
            end
        end
    endtask

    initial begin
        logic [16:0] w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rd_seen = 1'b0;
                q.delete();
                pending = 0;
            end else begin
                if (rd_seen) begin
                    if (q.size() == 0) begin
                        for (int i = 0; i < 16; i++) q.push_back(17'h0);
                    end
                    w = q.pop_front();
                    mess_to_core = w[15:0];
                    if (w[16]) pending--;
                end
                rd_seen = core_reading0;
            end
        end
    end

    initial begin
        int t;
        int stall_cnt;
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.reading", core_reading0, 0);
        check("rst.ready", core_ready0, 1);
        check("rst.valid", task_valid0, 0);
        check("rst.r0", r0_value0, 0);
        check("rst.len", instr_len0, 0);
        check("rst.ovf", err_ovf0, 0);
        check("rst.busy", err_busy0, 0);
        reset = 1'b1;

        // Selected 2-frame load; the depth-16 instance overflows
        gen_pl(32, 1'b1);
        send_msg(2, 16'h0008, 16'h0100);
        wait_drain();
        check("A.r0_const", r0_value0, 16'h0103);
        check("A.len_const", instr_len0, 32);
        check("A.len16_const", instr_len1, 16);
        check("A.ovf16_const", err_ovf1, 1);
        check_all("A");
        pulse_done();
        check_all("A_done");

        // Unselected frames skipped, next header at word 48 must decode
        gen_pl(32, 1'b1);
        send_msg(2, 16'h0004, 16'h0100);
        gen_pl(16, 1'b0);
        send_msg(1, 16'h0008 | 16'($urandom), 16'($urandom));
        wait_drain();
        check_all("B");
        pulse_done();

        // Second selection while busy
        gen_pl(32, 1'b0);
        send_msg(2, 16'h0008, 16'($urandom));
        wait_drain();
        check_all("C1");
        gen_pl(16, 1'b0);
        send_msg(1, 16'h0008, 16'($urandom));
        wait_drain();
        check_all("C2");
        pulse_done();
        check_all("C3");

        // Selected with no instruction frames
        send_msg(0, 16'h0008, 16'($urandom));
        wait_drain();
        check_all("D");

        // Stall on word 7 of the first instruction frame
        gen_pl(32, 1'b0);
        send_msg(2, 16'h0008, 16'($urandom));
        t = 0;
        while (pending > 25 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("E.reach_word7", pending <= 25, 1);
        prog_loading = 1'b1;
        stall_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (!core_reading0) stall_cnt++;
        end
        prog_loading = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!core_reading0) stall_cnt++;
        end
        check("E.stall_cycles", stall_cnt, 5);
        wait_drain();
        check_all("E");
        pulse_done();

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) pulse_done();
            n = $urandom_range(0, 3);
            gen_pl(n * 16, 1'b0);
            send_msg(n, 16'($urandom), 16'($urandom));
            wait_drain();
            check_all($sformatf("R%0d", k));
        end

        // Reset in the middle of a load
        pulse_done();
        gen_pl(32, 1'b0);
        push_msg(2, 16'h0008, 16'($urandom));
        t = 0;
        while (pending > 20 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b0;
        #1;
        check("F.valid0", task_valid0, 0);
        check("F.ready0", core_ready0, 1);
        check("F.reading0", core_reading0, 0);
        check("F.ovf0", err_ovf0, 0);
        check("F.busy0", err_busy0, 0);
        check("F.ovf1", err_ovf1, 0);
        check("F.busy1", err_busy1, 0);
        check("F.len0", instr_len0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        gen_pl(16, 1'b0);
        send_msg(1, 16'h0008, 16'($urandom));
        wait_drain();
        check_all("G");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
